// File: rtl/div_pkg.sv
// Shared types and sizing constants for the iterative unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 16;

  // Iteration counter must hold WIDTH-1; a one-bit floor keeps WIDTH=2 legal.
  function automatic int cnt_width(input int w);
    return (w < 3) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_bk_sub.sv
// Combinational Brent-Kung prefix subtractor: diff = a + ~b + 1, cout=1 means a >= b.
module div_bk_sub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  always_comb begin
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N-1:0] w_h;
    logic [N-1:0] w_c;
    int           dTop;

    w_h  = a ^ ~b;
    w_p  = w_h;
    w_g  = a & ~b;
    // Carry-in is tied to 1, so it folds into the bit-0 group generate.
    w_g[0] = w_g[0] | w_p[0];
    dTop = 1;

    for (int d = 1; d < N; d = d * 2) begin
      dTop = d;
      for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i - d]);
        w_p[i] = w_p[i] & w_p[i - d];
      end
    end

    for (int d = dTop; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i - d]);
        w_p[i] = w_p[i] & w_p[i - d];
      end
    end

    w_c    = {w_g[N-2:0], 1'b1};
    diff   = w_h ^ w_c;
    cout   = w_g[N-1];
  end

endmodule

// File: rtl/div16u_iterative.sv
// Restoring radix-2 unsigned divider, one quotient bit per clock, valid/ready on both sides.
module div16u_iterative
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz;

  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_t;
  logic             w_cout;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_s        = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rem_next = w_cout ? w_t : w_s;
  assign w_q_next   = {r_q[WIDTH-2:0], w_cout};

  div_bk_sub #(.N(WIDTH + 1)) u_sub (
    .a    (w_s),
    .b    ({1'b0, r_d}),
    .diff (w_t),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next_state = (divisor == '0) ? DONE : CALC;
      CALC: if (r_cnt == '0) w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Result registers only move on entry to DONE, so they persist after consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              r_rem <= '0;
              r_q   <= dividend;
              r_d   <= divisor;
              r_cnt <= CW'(WIDTH - 1);
            end else begin
              r_quot    <= '1;
              r_rem_out <= dividend;
              r_dbz     <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_quot    <= w_q_next;
            r_rem_out <= w_rem_next[WIDTH-1:0];
            r_dbz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div16u_iterative.sv
// Directed and randomized self-checking bench for div16u_iterative and its prefix subtractor.
module tb_div16u_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [15:0] dividendIn;
  logic [15:0] divisorIn;
  logic        outValid;
  logic        outReady;
  logic [15:0] quotientOut;
  logic [15:0] remainderOut;
  logic        divByZero;

  logic [16:0] bkA;
  logic [16:0] bkB;
  logic [16:0] bkDiff;
  logic        bkCout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div16u_iterative #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .dividend    (dividendIn),
    .divisor     (divisorIn),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .quotient    (quotientOut),
    .remainder   (remainderOut),
    .div_by_zero (divByZero)
  );

  div_bk_sub #(.N(17)) subDut (
    .a    (bkA),
    .b    (bkB),
    .diff (bkDiff),
    .cout (bkCout)
  );

  // All driving and sampling happens 1ns after a rising edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (inReady !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_op_in_ready got=%b exp=1", inReady);
    end
    inValid = 1'b1; dividendIn = a; divisorIn = b;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (outValid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_valid_timeout got=%b exp=1", outValid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; dividendIn = '0; divisorIn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({inReady, outValid, quotientOut, remainderOut, divByZero} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state got rdy=%b vld=%b q=%h r=%h z=%b exp rdy=1 vld=0 q=0 r=0 z=0",
               inReady, outValid, quotientOut, remainderOut, divByZero);
    end
  endtask

  task automatic test_basic();
    int cyc;
    outReady = 1'b1;
    start_op(16'd100, 16'd7);
    wait_valid(cyc);
    checks++;
    if (cyc !== 16) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=16", cyc); end
    checks++;
    if ({quotientOut, remainderOut, divByZero} !== {16'd14, 16'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_result got q=%0d r=%0d z=%b exp q=14 r=2 z=0", quotientOut, remainderOut, divByZero);
    end
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_ready got=%b exp=0", inReady); end
    @(posedge clk); #1;
    checks++;
    if ({inReady, outValid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL basic_return_idle got rdy=%b vld=%b exp rdy=1 vld=0", inReady, outValid);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] va [6] = '{16'hFFFF, 16'hFFFF, 16'd3,  16'd0, 16'hFFFF, 16'h8000};
    logic [15:0] vb [6] = '{16'h0001, 16'hFFFF, 16'd10, 16'd5, 16'h0002, 16'h8001};
    logic [15:0] eq [6] = '{16'hFFFF, 16'h0001, 16'd0,  16'd0, 16'h7FFF, 16'h0000};
    logic [15:0] er [6] = '{16'h0000, 16'h0000, 16'd3,  16'd0, 16'h0001, 16'h8000};
    int cyc;
    outReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      start_op(va[k], vb[k]);
      wait_valid(cyc);
      checks++;
      if ({quotientOut, remainderOut, divByZero} !== {eq[k], er[k], 1'b0}) begin
        errors++;
        $display("[TB] FAIL extreme_%0d got q=%h r=%h z=%b exp q=%h r=%h z=0",
                 k, quotientOut, remainderOut, divByZero, eq[k], er[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_by_zero();
    int cyc;
    outReady = 1'b1;
    start_op(16'd5, 16'd0);
    wait_valid(cyc);
    checks++;
    if (cyc !== 0) begin errors++; $display("[TB] FAIL dbz_latency got=%0d exp=0", cyc); end
    checks++;
    if ({quotientOut, remainderOut, divByZero} !== {16'hFFFF, 16'd5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL dbz_result got q=%h r=%0d z=%b exp q=ffff r=5 z=1", quotientOut, remainderOut, divByZero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    outReady = 1'b0;
    start_op(16'd1000, 16'd33);
    repeat (5) begin
      inValid = 1'b1; dividendIn = 16'd77; divisorIn = 16'd0;
      @(posedge clk); #1; cyc++;
    end
    inValid = 1'b0;
    while (outValid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 16) begin errors++; $display("[TB] FAIL bp_latency got=%0d exp=16", cyc); end
    for (int k = 0; k < 5; k++) begin
      inValid = 1'b1; dividendIn = 16'd9; divisorIn = 16'd0;
      checks++;
      if ({outValid, inReady, quotientOut, remainderOut, divByZero} !== {1'b1, 1'b0, 16'd30, 16'd10, 1'b0}) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d got vld=%b rdy=%b q=%0d r=%0d z=%b exp vld=1 rdy=0 q=30 r=10 z=0",
                 k, outValid, inReady, quotientOut, remainderOut, divByZero);
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0; outReady = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({outValid, inReady, quotientOut, remainderOut} !== {1'b0, 1'b1, 16'd30, 16'd10}) begin
      errors++;
      $display("[TB] FAIL bp_consume got vld=%b rdy=%b q=%0d r=%0d exp vld=0 rdy=1 q=30 r=10",
               outValid, inReady, quotientOut, remainderOut);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit sawValid = 1'b0;
    outReady = 1'b1;
    start_op(16'd40000, 16'd3);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({inReady, outValid, quotientOut, remainderOut, divByZero} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_state got rdy=%b vld=%b q=%h r=%h z=%b exp rdy=1 vld=0 q=0 r=0 z=0",
               inReady, outValid, quotientOut, remainderOut, divByZero);
    end
    repeat (20) begin
      if (outValid === 1'b1) sawValid = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_phantom got=1 exp=0"); end
    start_op(16'd9, 16'd4);
    wait_valid(cyc);
    checks++;
    if ({quotientOut, remainderOut, divByZero} !== {16'd2, 16'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_next got q=%0d r=%0d z=%b exp q=2 r=1 z=0", quotientOut, remainderOut, divByZero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int cyc;
    logic [15:0] a, b, eq, er;
    for (int k = 0; k < 300; k++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 16));
      eq = (b == 0) ? 16'hFFFF : a / b;
      er = (b == 0) ? a : a % b;
      outReady = 1'b0;
      start_op(a, b);
      wait_valid(cyc);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      checks++;
      if ({quotientOut, remainderOut, divByZero} !== {eq, er, (b == 16'd0)}) begin
        errors++;
        $display("[TB] FAIL random_%0d %h/%h got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                 k, a, b, quotientOut, remainderOut, divByZero, eq, er, (b == 16'd0));
      end
      if (b != 16'd0) begin
        checks++;
        if ((32'(quotientOut) * 32'(b) + 32'(remainderOut) !== 32'(a)) || !(remainderOut < b)) begin
          errors++;
          $display("[TB] FAIL random_invariant_%0d %h/%h got q=%h r=%h", k, a, b, quotientOut, remainderOut);
        end
      end
      outReady = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bk_sub();
    logic [16:0] ca [4] = '{17'd0, 17'h1FFFF, 17'h10000, 17'h0FFFF};
    logic [16:0] cb [4] = '{17'd0, 17'h1FFFF, 17'h0FFFF, 17'h10000};
    for (int k = 0; k < 204; k++) begin
      if (k < 4) begin bkA = ca[k]; bkB = cb[k]; end
      else begin bkA = 17'($urandom); bkB = 17'($urandom); end
      #1;
      checks++;
      if ({bkCout, bkDiff} !== {(bkA >= bkB), 17'(bkA - bkB)}) begin
        errors++;
        $display("[TB] FAIL bk_sub_%0d a=%h b=%h got cout=%b diff=%h exp cout=%b diff=%h",
                 k, bkA, bkB, bkCout, bkDiff, (bkA >= bkB), 17'(bkA - bkB));
      end
    end
  endtask

  initial begin
    bkA = '0; bkB = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_bk_sub();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
